// File: rtl/cce_deadlock_report_ctrl.sv
// rtl/cce_deadlock_report_ctrl.sv - persistence-qualified deadlock capture with round-robin report channel
module cce_deadlock_report_ctrl #(
    parameter int NUM_MON  = 4,
    parameter int THRESH_W = 16,
    parameter int TS_W     = 32,
    localparam int ID_W    = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [THRESH_W-1:0] threshold,
    input  logic [NUM_MON-1:0]  block_in,
    input  logic                clear_in,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [ID_W-1:0]     rpt_id,
    output logic [TS_W-1:0]     rpt_ts,
    output logic [NUM_MON-1:0]  sticky,
    output logic                deadlock_irq
);

    typedef enum logic {S_IDLE, S_SEND} state_e;

    state_e              state_q, state_d;
    logic [TS_W-1:0]     ts_q;
    logic [THRESH_W-1:0] run_q    [NUM_MON];
    logic [TS_W-1:0]     ts_mem_q [NUM_MON];
    logic [NUM_MON-1:0]  sticky_q, pending_q, qualify, grant_mask;
    logic [ID_W-1:0]     rr_last_q, rr_last_d, rpt_id_q, rpt_id_d;
    logic [TS_W-1:0]     rpt_ts_q, rpt_ts_d;
    logic                irq_q;
    logic [THRESH_W-1:0] thr_eff;
    logic                found;
    int                  cand, idx;

    assign thr_eff = (threshold == '0) ? THRESH_W'(1) : threshold;

    // Compare run+1 one bit wider so a saturated counter never wraps below threshold.
    always_comb begin
        qualify = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            qualify[i] = enable && block_in[i] && !sticky_q[i] &&
                         (({1'b0, run_q[i]} + {{THRESH_W{1'b0}}, 1'b1}) >= {1'b0, thr_eff});
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        rpt_id_d   = rpt_id_q;
        rpt_ts_d   = rpt_ts_q;
        grant_mask = '0;
        found      = 1'b0;
        cand       = 0;
        idx        = 0;
        case (state_q)
            S_IDLE: begin
                if (enable && (|pending_q)) begin
                    // Search starts just after the last granted monitor and wraps around.
                    for (int k = 1; k <= NUM_MON; k++) begin
                        cand = int'(rr_last_q) + k;
                        if (cand >= NUM_MON) cand = cand - NUM_MON;
                        if (!found && pending_q[cand]) begin
                            found = 1'b1;
                            idx   = cand;
                        end
                    end
                    state_d         = S_SEND;
                    rpt_id_d        = ID_W'(idx);
                    rpt_ts_d        = ts_mem_q[idx];
                    rr_last_d       = ID_W'(idx);
                    grant_mask[idx] = 1'b1;
                end
            end
            S_SEND: begin
                if (rpt_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ts_q      <= '0;
            sticky_q  <= '0;
            pending_q <= '0;
            rr_last_q <= ID_W'(NUM_MON - 1);
            rpt_id_q  <= '0;
            rpt_ts_q  <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < NUM_MON; i++) begin
                run_q[i]    <= '0;
                ts_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_q + TS_W'(1);
            rr_last_q <= rr_last_d;
            rpt_id_q  <= rpt_id_d;
            rpt_ts_q  <= rpt_ts_d;
            irq_q     <= |sticky_q;
            for (int i = 0; i < NUM_MON; i++) begin
                if (clear_in || !enable || !block_in[i] || sticky_q[i]) begin
                    run_q[i] <= '0;
                end else if (run_q[i] != '1) begin
                    run_q[i] <= run_q[i] + THRESH_W'(1);
                end
                if (qualify[i] && !clear_in) ts_mem_q[i] <= ts_q;
            end
            // Clear overrides a qualification landing in the same cycle.
            if (clear_in) begin
                sticky_q  <= '0;
                pending_q <= '0;
            end else begin
                sticky_q  <= sticky_q | qualify;
                pending_q <= (pending_q & ~grant_mask) | qualify;
            end
        end
    end

    assign rpt_valid    = (state_q == S_SEND);
    assign rpt_id       = rpt_id_q;
    assign rpt_ts       = rpt_ts_q;
    assign sticky       = sticky_q;
    assign deadlock_irq = irq_q;

endmodule

// File: tb/tb_cce_deadlock_report_ctrl.sv
// tb/tb_cce_deadlock_report_ctrl.sv - directed and random checks of cce_deadlock_report_ctrl against a cycle model
module tb_cce_deadlock_report_ctrl;
    localparam int NM = 4;
    localparam int TW = 4;
    localparam int SW = 32;

    logic          clock = 1'b0;
    logic          reset, enable, clear_in, rpt_ready;
    logic [TW-1:0] threshold;
    logic [NM-1:0] block_in;
    logic          rpt_valid, deadlock_irq;
    logic [1:0]    rpt_id;
    logic [SW-1:0] rpt_ts;
    logic [NM-1:0] sticky;

    always #5 clock = ~clock;

    cce_deadlock_report_ctrl #(.NUM_MON(NM), .THRESH_W(TW), .TS_W(SW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .threshold(threshold),
        .block_in(block_in), .clear_in(clear_in), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_id(rpt_id), .rpt_ts(rpt_ts),
        .sticky(sticky), .deadlock_irq(deadlock_irq)
    );

    int total = 0;
    int bad   = 0;

    bit [NM-1:0]   m_sticky, m_pending;
    int            m_run [NM];
    logic [SW-1:0] m_tsv [NM];
    logic [SW-1:0] m_ts, m_rts;
    bit            m_busy, m_irq;
    int            m_id, m_rr;

    int            obs_id [$];
    logic [SW-1:0] obs_ts [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the reference behaviour, using the inputs present at this edge.
    task automatic model_step();
        bit [NM-1:0] q;
        int thr_e;
        if (reset) begin
            m_sticky = '0; m_pending = '0; m_ts = '0; m_rts = '0;
            m_busy = 0; m_irq = 0; m_id = 0; m_rr = NM - 1;
            for (int i = 0; i < NM; i++) begin m_run[i] = 0; m_tsv[i] = '0; end
            return;
        end
        thr_e = (threshold == 0) ? 1 : int'(threshold);
        q = '0;
        for (int i = 0; i < NM; i++)
            if (enable && block_in[i] && !m_sticky[i] && (m_run[i] + 1 >= thr_e)) q[i] = 1'b1;
        for (int i = 0; i < NM; i++) begin
            if (clear_in || !enable || !block_in[i] || m_sticky[i]) m_run[i] = 0;
            else if (m_run[i] < (1 << TW) - 1) m_run[i] = m_run[i] + 1;
        end
        m_irq = (m_sticky != 0);
        if (m_busy) begin
            if (rpt_ready) m_busy = 0;
        end else if (enable && m_pending != 0) begin
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (m_rr + k) % NM;
                if (m_pending[c]) begin m_id = c; break; end
            end
            m_busy = 1;
            m_rts = m_tsv[m_id];
            m_pending[m_id] = 1'b0;
            m_rr = m_id;
        end
        if (clear_in) begin
            m_sticky = '0; m_pending = '0;
        end else begin
            for (int i = 0; i < NM; i++)
                if (q[i]) begin m_sticky[i] = 1'b1; m_pending[i] = 1'b1; m_tsv[i] = m_ts; end
        end
        m_ts = m_ts + 1;
    endtask

    task automatic tick();
        if (rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
            obs_id.push_back(int'(rpt_id));
            obs_ts.push_back(rpt_ts);
        end
        @(posedge clock);
        model_step();
        #1;
        chk("rpt_valid", rpt_valid, m_busy);
        chk("rpt_id", rpt_id, m_id);
        chk("rpt_ts", rpt_ts, m_rts);
        chk("sticky", sticky, m_sticky);
        chk("irq", deadlock_irq, m_irq);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1; tick(); clear_in = 1'b0;
    endtask

    logic [SW-1:0] exp_ts;

    initial begin
        reset = 1'b1; enable = 1'b0; clear_in = 1'b0; rpt_ready = 1'b0;
        threshold = '0; block_in = '0;
        run(3);
        chk("reset_valid", rpt_valid, 0);
        chk("reset_sticky", sticky, 0);
        chk("reset_irq", deadlock_irq, 0);
        chk("reset_ts", rpt_ts, 0);
        reset = 1'b0; enable = 1'b1;

        // T2: three simultaneous qualifications reported in index order
        threshold = 1; rpt_ready = 1'b1; obs_id.delete(); obs_ts.delete();
        exp_ts = m_ts; block_in = 4'b1011; tick(); block_in = '0;
        run(10);
        chk("t2_count", obs_id.size(), 3);
        if (obs_id.size() == 3) begin
            chk("t2_id0", obs_id[0], 0); chk("t2_id1", obs_id[1], 1); chk("t2_id2", obs_id[2], 3);
            chk("t2_ts0", obs_ts[0], exp_ts); chk("t2_ts2", obs_ts[2], exp_ts);
        end

        // T3: round-robin restarts after id 3
        pulse_clear(); obs_id.delete();
        block_in = 4'b1001; tick(); block_in = '0;
        run(8);
        chk("t3_count", obs_id.size(), 2);
        if (obs_id.size() == 2) begin
            chk("t3_first", obs_id[0], 0); chk("t3_second", obs_id[1], 3);
        end

        // T1: persistence threshold of 3
        pulse_clear(); threshold = 3; rpt_ready = 1'b0;
        block_in = 4'b0010; run(2); block_in = '0; run(3);
        chk("t1_short_sticky", sticky, 0);
        chk("t1_short_valid", rpt_valid, 0);
        block_in = 4'b0010; run(2); exp_ts = m_ts; tick(); block_in = '0;
        run(2);
        chk("t1_sticky", sticky, 4'b0010);
        chk("t1_valid", rpt_valid, 1);
        chk("t1_id", rpt_id, 1);
        chk("t1_ts", rpt_ts, exp_ts);
        chk("t1_irq", deadlock_irq, 1);
        rpt_ready = 1'b1; tick();
        chk("t1_drop", rpt_valid, 0);

        // T4: backpressure keeps the report stable
        pulse_clear(); threshold = 1; rpt_ready = 1'b0; obs_id.delete();
        exp_ts = m_ts; block_in = 4'b0100; tick(); block_in = '0;
        run(2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_valid", rpt_valid, 1);
            chk("t4_hold_id", rpt_id, 2);
            chk("t4_hold_ts", rpt_ts, exp_ts);
        end
        rpt_ready = 1'b1; tick();
        chk("t4_drop", rpt_valid, 0);
        chk("t4_count", obs_id.size(), 1);

        // T5: clear beats qualification, and clear during SEND
        pulse_clear(); obs_id.delete();
        block_in = 4'b0100; clear_in = 1'b1; tick(); clear_in = 1'b0; block_in = '0;
        run(4);
        chk("t5_sticky", sticky, 0);
        chk("t5_noreport", obs_id.size(), 0);
        rpt_ready = 1'b0;
        block_in = 4'b0011; tick(); block_in = '0;
        run(2);
        pulse_clear();
        run(2);
        chk("t5_inflight_valid", rpt_valid, 1);
        chk("t5_inflight_id", rpt_id, 0);
        rpt_ready = 1'b1; run(6);
        chk("t5_count", obs_id.size(), 1);
        chk("t5_sticky_after", sticky, 0);

        // T6: threshold 0 acts as 1; long block gives a single report
        threshold = 0; block_in = 4'b0001; tick(); block_in = '0; tick();
        chk("t6_thr0", sticky, 4'b0001);
        run(4);
        pulse_clear(); threshold = 15; obs_id.delete();
        block_in = 4'b1000; run(40); block_in = '0; run(4);
        chk("t6_count", obs_id.size(), 1);
        if (obs_id.size() == 1) chk("t6_id", obs_id[0], 3);

        // enable=0 blocks qualification and grants but keeps pending
        pulse_clear(); obs_id.delete(); threshold = 1;
        enable = 1'b0; block_in = 4'b1111; run(5);
        chk("en0_sticky", sticky, 0);
        enable = 1'b1; block_in = 4'b0001; tick();
        enable = 1'b0; block_in = '0; run(5);
        chk("en0_novalid", rpt_valid, 0);
        chk("en0_pending_sticky", sticky, 4'b0001);
        enable = 1'b1; run(3);
        chk("en0_count", obs_id.size(), 1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            threshold = TW'($urandom_range(0, 4));
            block_in  = NM'($urandom_range(0, 15) | $urandom_range(0, 15));
            clear_in  = ($urandom_range(0, 39) == 0);
            rpt_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset = 1'b0; clear_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
